// File: rtl/mem_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : mem_arb_pkg
// Purpose  : Shared types and default widths for the two-client memory arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mem_arb_state_e;

  localparam int NUM_CLIENTS        = 2;
  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_TIMEOUT    = 16;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_2.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter_2
// Purpose  : Combinational two-way round-robin select; one-hot winner output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter_2
  import mem_arb_pkg::*;
(
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic                   prio,   // client favoured when both request
  output logic [NUM_CLIENTS-1:0] win
);

  always_comb begin
    win = req;
    if (req == 2'b11) begin
      win = prio ? 2'b10 : 2'b01;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter and access sequencer in front of a single-port
//            Memory. Optional WAIT timeout enabled by `define MEM_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CLIENTS-1:0]            req,
  input  logic [NUM_CLIENTS-1:0]            wr,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] wdata,
  output logic [NUM_CLIENTS-1:0]            gnt,
  output logic [NUM_CLIENTS-1:0]            done,
  output logic [DATA_WIDTH-1:0]             rdata,
  output logic                              err,
  output logic                              mem_en,
  output logic                              mem_wr,
  output logic [ADDR_WIDTH-1:0]             mem_address,
  output logic [DATA_WIDTH-1:0]             mem_data_in,
  input  logic [DATA_WIDTH-1:0]             mem_data_out,
  input  logic                              mem_valid_out
);

  mem_arb_state_e state, state_n;

  logic [NUM_CLIENTS-1:0] win;
  logic                   prio, prio_n;
  logic                   owner, owner_n;
  logic                   cur_wr, cur_wr_n;

  logic [NUM_CLIENTS-1:0] gnt_n, done_n;
  logic [DATA_WIDTH-1:0]  rdata_n;
  logic                   mem_en_n, mem_wr_n;
  logic [ADDR_WIDTH-1:0]  mem_address_n;
  logic [DATA_WIDTH-1:0]  mem_data_in_n;

  logic                   sel_wr;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic [NUM_CLIENTS-1:0] owner_onehot;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
  logic             err_n;
`endif

  rr_arbiter_2 u_rr (
    .req  (req),
    .prio (prio),
    .win  (win)
  );

  assign sel_wr       = win[1] ? wr[1] : wr[0];
  assign sel_addr     = win[1] ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr[ADDR_WIDTH-1:0];
  assign sel_wdata    = win[1] ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];
  assign owner_onehot = owner ? 2'b10 : 2'b01;

  // Every output is computed one cycle early and registered, so the ISSUE and
  // RESP pulses appear in the cycle named by the state being entered.
  always_comb begin
    state_n       = state;
    prio_n        = prio;
    owner_n       = owner;
    cur_wr_n      = cur_wr;
    gnt_n         = '0;
    done_n        = '0;
    rdata_n       = '0;
    mem_en_n      = 1'b0;
    mem_wr_n      = 1'b0;
    mem_address_n = '0;
    mem_data_in_n = '0;
`ifdef MEM_ARB_TIMEOUT_EN
    err_n         = 1'b0;
    wait_cnt_n    = wait_cnt;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          state_n       = ISSUE;
          owner_n       = win[1];
          prio_n        = ~win[1];
          cur_wr_n      = sel_wr;
          gnt_n         = win;
          mem_en_n      = 1'b1;
          mem_wr_n      = sel_wr;
          mem_address_n = sel_addr;
          mem_data_in_n = sel_wdata;
        end
      end
      ISSUE: begin
        state_n = WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
        wait_cnt_n = '0;
`endif
      end
      WAIT: begin
        if (mem_valid_out) begin
          state_n = RESP;
          done_n  = owner_onehot;
          rdata_n = cur_wr ? '0 : mem_data_out;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (wait_cnt == CNT_LAST) begin
          state_n = RESP;
          done_n  = owner_onehot;
          err_n   = 1'b1;
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
`endif
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      prio        <= 1'b0;
      owner       <= 1'b0;
      cur_wr      <= 1'b0;
      gnt         <= '0;
      done        <= '0;
      rdata       <= '0;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
    end else begin
      state       <= state_n;
      prio        <= prio_n;
      owner       <= owner_n;
      cur_wr      <= cur_wr_n;
      gnt         <= gnt_n;
      done        <= done_n;
      rdata       <= rdata_n;
      mem_en      <= mem_en_n;
      mem_wr      <= mem_wr_n;
      mem_address <= mem_address_n;
      mem_data_in <= mem_data_in_n;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_n;
      err      <= err_n;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_arbiter
// Purpose  : Directed bench for mem_arbiter with a transaction-level reference.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req, wr;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [1:0]    gnt, done;
  logic [DW-1:0] rdata;
  logic          err;
  logic          mem_en, mem_wr;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;
  wire           mem_valid_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .err(err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_valid_out(mem_valid_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] data_for(input logic [AW-1:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Memory stand-in: answers 'lat' cycles after the en cycle (lat=0: never).
  int            lat = 1;
  int            cd  = 0;
  logic          resp_valid = 1'b0;
  logic          stray = 1'b0;
  logic [AW-1:0] resp_addr = '0;
  assign mem_valid_out = resp_valid | stray;

  initial mem_data_out = 32'hBAD0BAD0;
  always @(negedge clk) begin
    if (resp_valid) begin
      resp_valid   = 1'b0;
      mem_data_out = 32'hBAD0BAD0;
    end
    if (rst) cd = 0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        resp_valid   = 1'b1;
        mem_data_out = data_for(resp_addr);
      end
    end
    if (mem_en && lat > 0) begin
      cd        = lat;
      resp_addr = mem_address;
    end
  end

  // Reference: one access at a time; grant a cycle after acceptance, done a
  // cycle after the memory answers, then one quiet cycle before the next accept.
  logic [1:0]    e_gnt, e_done;
  logic [DW-1:0] e_rdata, e_wd;
  logic          e_err, e_en, e_wr;
  logic [AW-1:0] e_addr;
  bit            model_ready = 0;
  bit            busy = 0, issued = 0, settle = 0;
  int            client = 0, prio_m = 0, waits = 0;
  logic          t_wr;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wd;

  task automatic model_complete(input bit timed_out);
    e_done  = (client == 1) ? 2'b10 : 2'b01;
    e_err   = timed_out;
    e_rdata = (timed_out || t_wr) ? '0 : data_for(t_addr);
    busy    = 0;
    settle  = 1;
  endtask

  always @(posedge clk) begin
    e_gnt = '0; e_done = '0; e_rdata = '0; e_err = 1'b0;
    e_en = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0;
    model_ready = 1;
    if (rst) begin
      busy = 0; issued = 0; settle = 0; prio_m = 0;
    end else if (settle) begin
      settle = 0;
    end else if (!busy) begin
      if (req != 2'b00) begin
        client = (req == 2'b11) ? prio_m : (req[1] ? 1 : 0);
        prio_m = 1 - client;
        busy   = 1; issued = 0; waits = 0;
        t_wr   = wr[client];
        t_addr = addr[client*AW +: AW];
        t_wd   = wdata[client*DW +: DW];
        e_gnt  = (client == 1) ? 2'b10 : 2'b01;
        e_en = 1'b1; e_wr = t_wr; e_addr = t_addr; e_wd = t_wd;
      end
    end else if (!issued) begin
      issued = 1;
    end else if (mem_valid_out) begin
      model_complete(1'b0);
    end else begin
      waits++;
`ifdef MEM_ARB_TIMEOUT_EN
      if (waits == TO) model_complete(1'b1);
`endif
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      check("cmp gnt", 64'(gnt), 64'(e_gnt));
      check("cmp done", 64'(done), 64'(e_done));
      check("cmp rdata", 64'(rdata), 64'(e_rdata));
      check("cmp err", 64'(err), 64'(e_err));
      check("cmp mem_en", 64'(mem_en), 64'(e_en));
      check("cmp mem_wr", 64'(mem_wr), 64'(e_wr));
      check("cmp mem_address", 64'(mem_address), 64'(e_addr));
      check("cmp mem_data_in", 64'(mem_data_in), 64'(e_wd));
    end
  end

  task automatic wait_gnt(input string name, input int bound);
    bit seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin seen = 1; break; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: no gnt within %0d cycles (got 0, required pulse)", name, bound);
    end
  endtask

  task automatic wait_done(input string name, input int bound);
    bit seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done != 2'b00) begin seen = 1; break; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: no done within %0d cycles (got 0, required pulse)", name, bound);
    end
  endtask

  initial begin
    int last;
    rst = 1'b1; req = '0; wr = '0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    check("reset gnt", 64'(gnt), 64'd0);
    check("reset mem_en", 64'(mem_en), 64'd0);
    check("reset rdata", 64'(rdata), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single read from client 0, memory answers two cycles after en.
    lat = 2; req = 2'b01; wr = 2'b00; addr = {8'h00, 8'h10}; wdata = '0;
    @(posedge clk);
    @(negedge clk);
    check("read gnt", 64'(gnt), 64'd1);
    check("read mem_address", 64'(mem_address), 64'h10);
    check("read mem_wr", 64'(mem_wr), 64'd0);
    req = 2'b00;
    repeat (3) @(negedge clk);
    check("read done", 64'(done), 64'd1);
    check("read rdata", 64'(rdata), 64'hDEADBEEF);
    @(negedge clk);

    // Write from client 1.
    lat = 1; req = 2'b10; wr = 2'b10; addr = {8'h22, 8'h00}; wdata = {32'h55, 32'h0};
    @(posedge clk);
    @(negedge clk);
    check("write gnt", 64'(gnt), 64'd2);
    check("write mem_wr", 64'(mem_wr), 64'd1);
    check("write mem_data_in", 64'(mem_data_in), 64'h55);
    req = 2'b00;
    wait_done("write done", 10);
    check("write done", 64'(done), 64'd2);
    check("write rdata", 64'(rdata), 64'd0);
    wr = 2'b00;
    @(negedge clk);

    // Stray valid in IDLE and ISSUE must not complete anything.
    stray = 1'b1;
    repeat (3) @(negedge clk);
    check("stray idle done", 64'(done), 64'd0);
    lat = 3; req = 2'b01; addr = {8'h00, 8'h31};
    @(posedge clk);
    @(negedge clk);
    check("stray gnt", 64'(gnt), 64'd1);
    req = 2'b00;
    @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    check("stray early done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    check("stray done", 64'(done), 64'd1);
    check("stray rdata", 64'(rdata), 64'(data_for(8'h31)));
    @(negedge clk);

    // Contention from reset: grants alternate, one every 4 cycles.
    rst = 1'b1; req = 2'b11; lat = 1; addr = {8'h44, 8'h40};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt("contention gnt", 10);
      check("contention order", 64'(gnt), (k % 2 == 0) ? 64'd1 : 64'd2);
      if (k > 0) check("contention spacing", 64'(cyc - last), 64'd4);
      last = cyc;
    end
    req = 2'b00;
    wait_done("contention last done", 10);
    repeat (2) @(negedge clk);

    // Client 0 waits on a silent memory (long WAIT / timeout).
    lat = 0; req = 2'b01; addr = {8'h00, 8'h77};
    @(posedge clk);
    @(negedge clk);
    req = 2'b00;
    repeat (16) @(negedge clk);
    check("silent no early done", 64'(done), 64'd0);
    @(negedge clk);
`ifdef MEM_ARB_TIMEOUT_EN
    check("timeout done", 64'(done), 64'd1);
    check("timeout err", 64'(err), 64'd1);
    check("timeout rdata", 64'(rdata), 64'd0);
    repeat (2) @(negedge clk);
`else
    check("hold no done", 64'(done), 64'd0);
    check("hold err", 64'(err), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif

    // Reset in WAIT after granting client 0: abandon, then client 0 first again.
    lat = 0; req = 2'b01; addr = {8'h00, 8'h12};
    @(posedge clk);
    @(negedge clk);
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst mem_en", 64'(mem_en), 64'd0);
    check("rst done", 64'(done), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst no late done", 64'(done), 64'd0);
    lat = 1; req = 2'b11; addr = {8'h66, 8'h65};
    wait_gnt("post-reset gnt", 10);
    check("post-reset order", 64'(gnt), 64'd1);
    req = 2'b00;
    wait_done("post-reset done", 10);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

- Two-client round-robin arbiter and access sequencer for the single-port `Memory` block.
- Accepts read/write requests from two requesters, grants one at a time, and drives the memory's `en`/`data_in`/`address` inputs.
- Waits for `valid_out`, then returns read data and a completion pulse to the granted client.
- Sits between client logic and `Memory`; the memory itself is unchanged.

## Interface
Parameters:
- ADDR_WIDTH, 8, address width of memory and clients
- DATA_WIDTH, 32, data width
- TIMEOUT, 16, max WAIT cycles before error (used only with the timeout feature)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  2  per-client request, bit i = client i
- wr  in  2  per-client write flag (1 = write, 0 = read)
- addr  in  2*ADDR_WIDTH  client i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
- wdata  in  2*DATA_WIDTH  client i write data, same packing
- gnt  out  2  one-cycle grant pulse, one-hot
- done  out  2  one-cycle completion pulse, one-hot
- rdata  out  DATA_WIDTH  read data, valid while done != 0
- err  out  1  timeout flag, valid while done != 0
- mem_en  out  1  to Memory `en`
- mem_wr  out  1  write qualifier to Memory
- mem_address  out  ADDR_WIDTH  to Memory `address`
- mem_data_in  out  DATA_WIDTH  to Memory `data_in`
- mem_data_out  in  DATA_WIDTH  from Memory `data_out`
- mem_valid_out  in  1  from Memory `valid_out`; completion for reads and writes

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req` is high, select a winner and register its wr/addr/wdata.
  - Set the grant pointer to the winner; go to ISSUE.
  - If no request, stay in IDLE.
- **ISSUE** (exactly 1 cycle)
  - `mem_en`=1; `mem_wr`/`mem_address`/`mem_data_in` = registered values.
  - `gnt[winner]`=1; go to WAIT.
- **WAIT**
  - All mem_* outputs are 0.
  - On `mem_valid_out`=1, capture `mem_data_out` (reads only; writes capture 0) and go to RESP.
- **RESP** (exactly 1 cycle)
  - `done[winner]`=1, `rdata` = captured value, `err`=0; go to IDLE.
- **Arbitration**
  - Round-robin: with both requesting, the client not granted last wins.
  - After reset, client 0 has priority.
  - A single requester always wins.
- **Client protocol**
  - Hold req/wr/addr/wdata until `gnt`; may drop `req` afterwards.
  - `req` still high in the IDLE cycle after RESP is a new request.
- `mem_valid_out` is ignored outside WAIT.
- Reset mid-operation
  - State goes to IDLE, all outputs to 0, pointer to client 0.
  - The in-flight access is abandoned with no `done`; the client reissues.

## Timing
- Reset values: gnt=0, done=0, rdata=0, err=0, mem_en=0, mem_wr=0, mem_address=0, mem_data_in=0.
- `req` sampled high at edge 0 (IDLE):
  - ISSUE during cycle 1 (`gnt`, `mem_en` high).
  - WAIT from cycle 2.
  - `mem_valid_out` in cycle n ≥ 2 gives RESP (`done`) in cycle n+1.
  - IDLE in cycle n+2.
- Minimum req-to-done latency: 3 cycles.
- Back-to-back throughput: one access per 4 cycles (mandatory IDLE cycle).
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: `MEM_ARB_TIMEOUT_EN`.
- **Defined**
  - A WAIT-cycle counter (width $clog2(TIMEOUT+1)) runs in WAIT.
  - After TIMEOUT cycles in WAIT without `mem_valid_out`, go to RESP with `err`=1 and `rdata`=0.
  - `mem_valid_out` on the same cycle the count expires takes precedence (normal completion, `err`=0).
- **Undefined**
  - No counter; WAIT holds indefinitely.
  - `err` is tied to 0.
  - The TIMEOUT parameter is unused.

## Structure
- Package `mem_arb_pkg`:
  - state enum `mem_arb_state_e` {IDLE, ISSUE, WAIT, RESP}
  - `NUM_CLIENTS` = 2
  - default width constants
- Sub-module `rr_arbiter_2`:
  - Combinational two-way round-robin select from `req` and the last-grant pointer.
  - Outputs a one-hot winner.
  - Pointer register stays in `mem_arb_state`'s owning module.

## Test plan
- Single read: client 0 req, addr=0x10, mem returns 0xDEADBEEF 2 cycles after en
  - gnt[0] at cycle 1, mem_address=0x10, mem_wr=0
  - done[0] at cycle 4, rdata=0xDEADBEEF
- Write: client 1 wr=1, addr=0x22, wdata=0x55
  - mem_en with mem_wr=1, mem_data_in=0x55
  - done[1] after valid, rdata=0
- Contention: both req held continuously from reset
  - grants alternate 0,1,0,1 across four accesses, one per 4 cycles with immediate valid
- Timeout (macro defined, TIMEOUT=16): memory never asserts valid
  - done with err=1, rdata=0 exactly 16 cycles after entering WAIT
- Reset mid-WAIT: assert rst for one cycle during WAIT
  - all outputs 0 next cycle, no done
  - next contention grants client 0 first
- Stray `mem_valid_out` asserted in IDLE and ISSUE: ignored, state unchanged.
